mem_request_arbiter: RTL and testbench
======================================

# mem_request_arbiter

Parametrised N-client arbiter between memory clients (VGA fetch, CPU instruction fetch, CPU data access, future UART) and the single Wishbone-side memory port. It grants one client at a time, drives the memory strobes, follows the `mem_busy` handshake, and returns read data with a one-cycle completion pulse to the granted client. Arbitration is either fixed-priority or round-robin, selected by parameter.

## Interface
- `NUM_CLIENTS`, 3: number of clients, 2..8; index 0 is VGA by convention.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, multiple of 8; SEL_W = DATA_W/8 (localparam).
- `RR_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.

- `clk`  in  1  system clock. One clock; all state on rising edge.
- `nRst`  in  1  reset, asynchronous, active-low.
- `client_req`  in  NUM_CLIENTS  level request; held until that client's `client_done`.
- `client_write`  in  NUM_CLIENTS  1 = write, 0 = read.
- `client_adr`  in  NUM_CLIENTS*ADDR_W  packed addresses; client i at slice i.
- `client_wdata`  in  NUM_CLIENTS*DATA_W  packed write data.
- `client_sel`  in  NUM_CLIENTS*SEL_W  packed byte selects.
- `client_rdata`  out  NUM_CLIENTS*DATA_W  per-client read data, held between reads.
- `client_done`  out  NUM_CLIENTS  one-cycle completion pulse.
- `client_grant`  out  NUM_CLIENTS  one-hot current owner; 0 when idle.
- `mem_busy`  in  1  memory handshake busy.
- `data_from_mem`  in  DATA_W  read data from memory.
- `mem_read`, `mem_write`  out  1  memory strobes.
- `adr_to_mem`  out  ADDR_W  address to memory.
- `data_to_mem`  out  DATA_W  write data to memory.
- `sel_to_mem`  out  SEL_W  byte selects to memory.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `client_req`, pick winner, register its write/adr/wdata/sel into mem outputs, set `client_grant`, -> ISSUE. Else stay; all mem outputs 0.
- ISSUE: `mem_read` = !write, `mem_write` = write. When `mem_busy`=1 -> WAIT, strobes cleared to 0; adr/data/sel held.
- WAIT: when `mem_busy`=0 -> DONE; on a read, capture `data_from_mem` into winner's `client_rdata` slice on that edge.
- DONE: `client_done[winner]`=1 for this cycle only; no arbitration; next edge -> IDLE, grant and all mem outputs cleared.
- Fixed priority: lowest asserted index. Round-robin: search starts at pointer; pointer <= winner+1 (mod NUM_CLIENTS) on grant.
- Write transactions leave `client_rdata` unchanged.
- Client dropping `client_req` mid-transaction: transaction still completes and `client_done` still pulses.
- Requests changing while a transaction is in flight are ignored until IDLE.
- Reset (any state, including WAIT): async return to IDLE; all outputs 0, `client_rdata` all 0, RR pointer 0. An in-flight memory access is abandoned without done.

## Timing
- Reset values: every output 0; state IDLE.
- Request sampled at edge E0 in IDLE -> strobe and grant visible after E0.
- `mem_busy`=1 sampled at E1 -> strobe low after E1.
- `mem_busy`=0 sampled at Ek -> rdata valid and `client_done` high after Ek, for one cycle.
- Minimum turnaround: 4 cycles request-to-next-grant (IDLE, ISSUE, WAIT, DONE).
- Strobe held indefinitely in ISSUE until `mem_busy` rises; no timeout.
- DONE cycle guarantees the finishing client can drop `client_req` before re-arbitration, so no duplicate grant.

## Structure
- `mem_arb_pkg`: `arb_state_t` (IDLE/ISSUE/WAIT/DONE), `RR_MODE` encodings `ARB_FIXED`/`ARB_RR`. Shared with the VGA and CPU-side modules.
- Sub-module `rr_pick`: combinational; inputs request vector, start pointer, mode; outputs one-hot grant and winner index. The FSM, registers and slicing stay in `mem_request_arbiter`.

## Test plan
- Reset: assert `nRst`=0 mid-WAIT -> all outputs 0 immediately, state IDLE; after release, no done pulse for the abandoned access.
- Single read: client 1 requests read at 0x000ABCDE, sel 4'hF. `mem_busy` rises 1 cycle later, falls 3 cycles after that with data 0xDEADBEEF -> `mem_read` high one cycle, `adr_to_mem`=0x000ABCDE, then `client_rdata[1]`=0xDEADBEEF and `client_done`=3'b010 for exactly one cycle.
- Write: client 2 writes 0x12345678 to 0x100, sel 4'b0011 -> `mem_write`=1, `data_to_mem`=0x12345678, `sel_to_mem`=4'b0011; `client_rdata[2]` unchanged.
- Fixed priority: RR_MODE=0, clients 0 and 2 request together -> client 0 served first, then client 2; grant 3'b001 then 3'b100.
- Round-robin: RR_MODE=1, all three clients hold requests continuously, re-requesting after each done -> grant sequence 0,1,2,0,1,2.
- Dropped request: client 1 deasserts `client_req` during WAIT -> transaction completes and `client_done[1]` still pulses once.

Source files
------------

// File: rtl/mem_request_arbiter_pkg.sv
// Shared arbiter types: FSM state encoding and arbitration-mode codes.
// Used by the arbiter and by the VGA / CPU-side memory clients.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/mem_request_arbiter_rr_pick.sv
// Combinational winner selection: lowest index in fixed mode,
// first requester at or after the pointer in round-robin mode.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          mode_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);
    import mem_arb_pkg::*;

    int          start;
    logic [IW-1:0] j;

    // Walk the request vector once from the start point, wrapping at N.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        j     = '0;
        start = mode_i ? int'(ptr_i) : 0;
        for (int i = 0; i < N; i++) begin
            j = IW'((start + i) % N);
            if (!vld_o && req_i[j]) begin
                vld_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/mem_request_arbiter.sv
// N-client arbiter onto a single memory port with busy handshake,
// per-client read data registers and a one-cycle completion pulse.
module mem_request_arbiter #(
    parameter  int NUM_CLIENTS = 3,
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int RR_MODE     = 0,
    localparam int SEL_W       = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          nRst,
    input  logic [NUM_CLIENTS-1:0]        client_req,
    input  logic [NUM_CLIENTS-1:0]        client_write,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] client_adr,
    input  logic [NUM_CLIENTS*DATA_W-1:0] client_wdata,
    input  logic [NUM_CLIENTS*SEL_W-1:0]  client_sel,
    output logic [NUM_CLIENTS*DATA_W-1:0] client_rdata,
    output logic [NUM_CLIENTS-1:0]        client_done,
    output logic [NUM_CLIENTS-1:0]        client_grant,
    input  logic                          mem_busy,
    input  logic [DATA_W-1:0]             data_from_mem,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic [ADDR_W-1:0]             adr_to_mem,
    output logic [DATA_W-1:0]             data_to_mem,
    output logic [SEL_W-1:0]              sel_to_mem
);
    import mem_arb_pkg::*;

    localparam int IW = $clog2(NUM_CLIENTS);

    arb_state_t                    state_q, state_d;
    logic [NUM_CLIENTS-1:0]        grant_q, grant_d;
    logic [NUM_CLIENTS-1:0]        done_q, done_d;
    logic [IW-1:0]                 idx_q, idx_d;
    logic [IW-1:0]                 ptr_q, ptr_d;
    logic                          wr_q, wr_d;
    logic                          rd_stb_q, rd_stb_d;
    logic                          wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0]             adr_q, adr_d;
    logic [DATA_W-1:0]             wdat_q, wdat_d;
    logic [SEL_W-1:0]              sel_q, sel_d;
    logic [NUM_CLIENTS*DATA_W-1:0] rdata_q, rdata_d;

    logic [NUM_CLIENTS-1:0] pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_vld;
    int                     pick_n;
    int                     own_n;

    rr_pick #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_pick (
        .req_i  (client_req),
        .ptr_i  (ptr_q),
        .mode_i (RR_MODE == ARB_RR),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    assign pick_n = int'(pick_idx);
    assign own_n  = int'(idx_q);

    // Transaction sequencing: latch winner, strobe, wait, complete.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = '0;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        wr_d     = wr_q;
        rd_stb_d = rd_stb_q;
        wr_stb_d = wr_stb_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        sel_d    = sel_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d  = pick_gnt;
                    idx_d    = pick_idx;
                    wr_d     = client_write[pick_idx];
                    rd_stb_d = !client_write[pick_idx];
                    wr_stb_d = client_write[pick_idx];
                    adr_d    = client_adr[pick_n*ADDR_W +: ADDR_W];
                    wdat_d   = client_wdata[pick_n*DATA_W +: DATA_W];
                    sel_d    = client_sel[pick_n*SEL_W +: SEL_W];
                    state_d  = ISSUE;
                    if (RR_MODE == ARB_RR) begin
                        if (pick_idx == IW'(NUM_CLIENTS - 1))
                            ptr_d = '0;
                        else
                            ptr_d = pick_idx + IW'(1);
                    end
                end
            end
            ISSUE: begin
                if (mem_busy) begin
                    rd_stb_d = 1'b0;
                    wr_stb_d = 1'b0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!mem_busy) begin
                    if (!wr_q)
                        rdata_d[own_n*DATA_W +: DATA_W] = data_from_mem;
                    done_d  = grant_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                wr_d    = 1'b0;
                adr_d   = '0;
                wdat_d  = '0;
                sel_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            wr_q     <= 1'b0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            adr_q    <= '0;
            wdat_q   <= '0;
            sel_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            wr_q     <= wr_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
        end
    end

    assign client_grant = grant_q;
    assign client_done  = done_q;
    assign client_rdata = rdata_q;
    assign mem_read     = rd_stb_q;
    assign mem_write    = wr_stb_q;
    assign adr_to_mem   = adr_q;
    assign data_to_mem  = wdat_q;
    assign sel_to_mem   = sel_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Bench: fixed-priority and round-robin instances side by side, each
// checked every cycle against a transaction-level model.
module tb_mem_request_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk  = 1'b0;
    logic nRst = 1'b0;

    logic [N-1:0]    req [2];
    logic [N-1:0]    wr  [2];
    logic [N*AW-1:0] adr [2];
    logic [N*DW-1:0] wd  [2];
    logic [N*SW-1:0] sel [2];
    logic            busy[2];
    logic [DW-1:0]   dfm [2];

    logic [N*DW-1:0] rd  [2];
    logic [N-1:0]    done[2];
    logic [N-1:0]    gnt [2];
    logic            mrd [2];
    logic            mwr [2];
    logic [AW-1:0]   ma  [2];
    logic [DW-1:0]   md  [2];
    logic [SW-1:0]   ms  [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_request_arbiter #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)
    ) u_fix (
        .clk(clk), .nRst(nRst),
        .client_req(req[0]), .client_write(wr[0]),
        .client_adr(adr[0]), .client_wdata(wd[0]),
        .client_sel(sel[0]), .client_rdata(rd[0]),
        .client_done(done[0]), .client_grant(gnt[0]),
        .mem_busy(busy[0]), .data_from_mem(dfm[0]),
        .mem_read(mrd[0]), .mem_write(mwr[0]),
        .adr_to_mem(ma[0]), .data_to_mem(md[0]),
        .sel_to_mem(ms[0])
    );

    mem_request_arbiter #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)
    ) u_rr (
        .clk(clk), .nRst(nRst),
        .client_req(req[1]), .client_write(wr[1]),
        .client_adr(adr[1]), .client_wdata(wd[1]),
        .client_sel(sel[1]), .client_rdata(rd[1]),
        .client_done(done[1]), .client_grant(gnt[1]),
        .mem_busy(busy[1]), .data_from_mem(dfm[1]),
        .mem_read(mrd[1]), .mem_write(mwr[1]),
        .adr_to_mem(ma[1]), .data_to_mem(md[1]),
        .sel_to_mem(ms[1])
    );

    // Model: ph 0 = no transaction, 1 = strobing, 2 = memory busy,
    // 3 = completion cycle. own = client index owning the port.
    int            ph  [2];
    int            own [2];
    int            ptr [2];
    bit            m_wr[2];
    logic [AW-1:0] m_a [2];
    logic [DW-1:0] m_d [2];
    logic [SW-1:0] m_s [2];
    logic [DW-1:0] m_rd[2][N];

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] = 0; own[k] = 0; ptr[k] = 0; m_wr[k] = 0;
                m_a[k] = '0; m_d[k] = '0; m_s[k] = '0;
                for (int c = 0; c < N; c++) m_rd[k][c] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (ph[k])
                    0: if (req[k] != '0) begin
                        int st;
                        int w;
                        st = (k == 1) ? ptr[k] : 0;
                        w  = -1;
                        for (int i = 0; i < N; i++)
                            if (w < 0 && req[k][(st + i) % N])
                                w = (st + i) % N;
                        own[k]  = w;
                        m_wr[k] = wr[k][w];
                        m_a[k]  = adr[k][w*AW +: AW];
                        m_d[k]  = wd[k][w*DW +: DW];
                        m_s[k]  = sel[k][w*SW +: SW];
                        if (k == 1) ptr[k] = (w + 1) % N;
                        ph[k] = 1;
                    end
                    1: if (busy[k]) ph[k] = 2;
                    2: if (!busy[k]) begin
                        if (!m_wr[k]) m_rd[k][own[k]] = dfm[k];
                        ph[k] = 3;
                    end
                    default: ph[k] = 0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (nRst) begin
            for (int k = 0; k < 2; k++) begin
                logic [N-1:0]    eg;
                logic [N-1:0]    ed;
                logic [N*DW-1:0] er;
                bit              act;
                act = (ph[k] != 0);
                eg  = act ? N'(1 << own[k]) : '0;
                ed  = (ph[k] == 3) ? N'(1 << own[k]) : '0;
                for (int c = 0; c < N; c++) er[c*DW +: DW] = m_rd[k][c];
                chk($sformatf("k%0d grant", k), gnt[k], eg);
                chk($sformatf("k%0d done", k), done[k], ed);
                chk($sformatf("k%0d mem_read", k), mrd[k],
                    ph[k] == 1 && !m_wr[k]);
                chk($sformatf("k%0d mem_write", k), mwr[k],
                    ph[k] == 1 && m_wr[k]);
                chk($sformatf("k%0d adr", k), ma[k], act ? m_a[k] : '0);
                chk($sformatf("k%0d wdata", k), md[k], act ? m_d[k] : '0);
                chk($sformatf("k%0d sel", k), ms[k], act ? m_s[k] : '0);
                chk($sformatf("k%0d rdata", k), rd[k], er);
            end
        end
    end

    task automatic nclk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setc(int c, bit w, logic [31:0] a,
                        logic [31:0] d, logic [3:0] s);
        for (int k = 0; k < 2; k++) begin
            req[k][c]          = 1'b1;
            wr[k][c]           = w;
            adr[k][c*AW +: AW] = a;
            wd[k][c*DW +: DW]  = d;
            sel[k][c*SW +: SW] = s;
        end
    endtask

    task automatic drop(int c);
        for (int k = 0; k < 2; k++) req[k][c] = 1'b0;
    endtask

    task automatic set_busy(bit b, logic [31:0] d);
        for (int k = 0; k < 2; k++) begin
            busy[k] = b;
            dfm[k]  = d;
        end
    endtask

    task automatic to_issue(int budget);
        int n;
        n = 0;
        do begin
            nclk(1);
            n++;
        end while (gnt[0] == '0 && n < budget);
        chk("grant within budget", gnt[0] != '0, 1);
    endtask

    task automatic serve(logic [31:0] d);
        set_busy(1'b1, '0);
        nclk(1);
        set_busy(1'b0, d);
        nclk(1);
    endtask

    task automatic zero_chk(string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s k%0d grant", tag, k), gnt[k], 0);
            chk($sformatf("%s k%0d done", tag, k), done[k], 0);
            chk($sformatf("%s k%0d strobes", tag, k), {mrd[k], mwr[k]}, 0);
            chk($sformatf("%s k%0d adr", tag, k), ma[k], 0);
            chk($sformatf("%s k%0d wdata", tag, k), md[k], 0);
            chk($sformatf("%s k%0d sel", tag, k), ms[k], 0);
            chk($sformatf("%s k%0d rdata", tag, k), rd[k], 0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            req[k] = '0; wr[k] = '0; adr[k] = '0; wd[k] = '0;
            sel[k] = '0; busy[k] = 1'b0; dfm[k] = '0;
        end
        nclk(2);
        zero_chk("reset");
        nRst = 1'b1;
        nclk(1);

        // Single read by client 1, busy high for three cycles
        setc(1, 1'b0, 32'h000ABCDE, 32'h0, 4'hF);
        to_issue(10);
        for (int k = 0; k < 2; k++) begin
            chk("rd grant", gnt[k], 3'b010);
            chk("rd strobe", mrd[k], 1);
            chk("rd adr", ma[k], 32'h000ABCDE);
            chk("rd sel", ms[k], 4'hF);
        end
        set_busy(1'b1, '0);
        nclk(1);
        for (int k = 0; k < 2; k++) chk("rd strobe drop", mrd[k], 0);
        nclk(2);
        set_busy(1'b0, 32'hDEADBEEF);
        nclk(1);
        for (int k = 0; k < 2; k++) begin
            chk("rd done", done[k], 3'b010);
            chk("rd data", rd[k][DW +: DW], 32'hDEADBEEF);
        end
        drop(1);
        nclk(1);
        for (int k = 0; k < 2; k++) begin
            chk("rd done once", done[k], 0);
            chk("rd grant clear", gnt[k], 0);
        end

        // Write by client 2 must not disturb its read data
        setc(2, 1'b1, 32'h100, 32'h12345678, 4'b0011);
        to_issue(10);
        for (int k = 0; k < 2; k++) begin
            chk("wr strobe", mwr[k], 1);
            chk("wr no read", mrd[k], 0);
            chk("wr data", md[k], 32'h12345678);
            chk("wr sel", ms[k], 4'b0011);
            chk("wr adr", ma[k], 32'h100);
        end
        serve(32'hCAFEF00D);
        for (int k = 0; k < 2; k++) begin
            chk("wr done", done[k], 3'b100);
            chk("wr rdata2", rd[k][2*DW +: DW], 0);
            chk("wr rdata1", rd[k][DW +: DW], 32'hDEADBEEF);
        end
        drop(2);
        nclk(1);

        // Clients 0 and 2 together
        setc(0, 1'b0, 32'h40, 32'h0, 4'hF);
        setc(2, 1'b0, 32'h80, 32'h0, 4'hF);
        to_issue(10);
        for (int k = 0; k < 2; k++) chk("prio first", gnt[k], 3'b001);
        serve(32'h11111111);
        drop(0);
        to_issue(10);
        for (int k = 0; k < 2; k++) chk("prio second", gnt[k], 3'b100);
        serve(32'h22222222);
        drop(2);
        nclk(1);

        // All clients hold requests continuously
        setc(0, 1'b0, 32'h400, 32'h0, 4'hF);
        setc(1, 1'b0, 32'h500, 32'h0, 4'hF);
        setc(2, 1'b0, 32'h600, 32'h0, 4'hF);
        for (int r = 0; r < 6; r++) begin
            logic [N-1:0] e;
            e = N'(1 << (r % 3));
            to_issue(10);
            chk($sformatf("rr grant %0d", r), gnt[1], e);
            chk($sformatf("fixed grant %0d", r), gnt[0], 3'b001);
            serve(32'(r + 32'hA0));
        end
        drop(0); drop(1); drop(2);
        nclk(2);

        // Client 1 drops its request while the memory is busy
        setc(1, 1'b0, 32'h200, 32'h0, 4'hF);
        to_issue(10);
        set_busy(1'b1, '0);
        nclk(1);
        drop(1);
        nclk(1);
        set_busy(1'b0, 32'h5A5A5A5A);
        nclk(1);
        for (int k = 0; k < 2; k++) begin
            chk("drop done", done[k], 3'b010);
            chk("drop data", rd[k][DW +: DW], 32'h5A5A5A5A);
        end
        nclk(1);
        for (int k = 0; k < 2; k++) chk("drop done once", done[k], 0);
        nclk(3);
        for (int k = 0; k < 2; k++) chk("drop no regrant", gnt[k], 0);

        // Reset while the memory is busy
        setc(0, 1'b0, 32'h300, 32'h0, 4'hF);
        to_issue(10);
        set_busy(1'b1, '0);
        nclk(1);
        #2 nRst = 1'b0;
        #1 zero_chk("async reset");
        nclk(1);
        drop(0);
        set_busy(1'b0, 32'h77777777);
        nclk(1);
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nclk(1);
            for (int k = 0; k < 2; k++) begin
                chk("post reset done", done[k], 0);
                chk("post reset grant", gnt[k], 0);
            end
        end

        // Randomised traffic with random busy timing
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                busy[k] = 1'($urandom_range(0, 1));
                dfm[k]  = $urandom;
                for (int c = 0; c < N; c++) begin
                    bit mine;
                    mine = (own[k] == c) && (ph[k] != 0);
                    if (!req[k][c] || (mine && ph[k] == 3)) begin
                        if (mine && ph[k] == 3 && $urandom_range(0, 1) == 0)
                            req[k][c] = 1'b0;
                        else if (req[k][c] || $urandom_range(0, 3) == 0) begin
                            req[k][c]          = 1'b1;
                            wr[k][c]           = 1'($urandom_range(0, 1));
                            adr[k][c*AW +: AW] = $urandom;
                            wd[k][c*DW +: DW]  = $urandom;
                            sel[k][c*SW +: SW] = SW'($urandom);
                        end
                    end else if (mine && $urandom_range(0, 15) == 0) begin
                        req[k][c] = 1'b0;
                    end
                end
            end
            if (cyc == 1500) begin
                #2 nRst = 1'b0;
                #2 nRst = 1'b1;
            end
        end

        nclk(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
